// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg
//   Shared types and constants for the FIFO read-side stream adapter.
//   cnt_t      : occupancy of the 2-entry holding buffer
//   CNT_*      : named occupancy values
//   BUF_DEPTH  : number of holding-buffer entries
//   BEAT_CNT_W : width of the optional accepted-beat counter
package fifo_stream_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_EMPTY = 2'd0;
  localparam cnt_t CNT_ONE   = 2'd1;
  localparam cnt_t CNT_TWO   = 2'd2;

  localparam int BUF_DEPTH  = 2;
  localparam int BEAT_CNT_W = 32;

endpackage

// File: rtl/stream_skid_buf2.sv
// stream_skid_buf2
//   Two-entry in-order holding buffer. Entry 0 is always the head; a pop
//   shifts entry 1 down, and a push lands in the first free slot after
//   that shift, so push and pop may happen in the same cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail this cycle
//   push_data  : data to append
//   pop        : remove the head this cycle (ignored when empty)
//   head_data  : current head entry
//   count      : number of valid entries (0..2)
module stream_skid_buf2
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output cnt_t                  count
);

  logic [DATA_WIDTH-1:0] entry_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] entry_d [BUF_DEPTH];
  cnt_t                  count_d;
  cnt_t                  wr_idx;
  logic                  pop_eff;

  assign pop_eff   = pop && (count != CNT_EMPTY);
  // After a pop the remaining entries sit one slot lower, so the tail
  // slot for an incoming push is the post-pop occupancy.
  assign wr_idx    = count - cnt_t'(pop_eff);
  assign head_data = entry_q[0];

  // Next-state of storage and occupancy: shift on pop first, then place
  // the pushed word into the slot that is free after the shift. The
  // producer never pushes into a full buffer without popping, so wr_idx
  // only ever selects slot 0 or 1.
  always_comb begin
    entry_d = entry_q;
    count_d = count + cnt_t'(push) - cnt_t'(pop_eff);
    if (pop_eff) begin
      entry_d[0] = entry_q[1];
    end
    if (push) begin
      if (wr_idx == CNT_EMPTY) begin
        entry_d[0] = push_data;
      end else begin
        entry_d[1] = push_data;
      end
    end
  end

  // Storage and occupancy registers; reset clears everything so the
  // head reads as zero while the buffer is empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      count <= CNT_EMPTY;
    end else begin
      entry_q <= entry_d;
      count   <= count_d;
    end
  end

endmodule

// File: rtl/fifo_stream_out.sv
// fifo_stream_out
//   Read-side adapter for an async FIFO (rd_clk domain). Issues fifo_rd_en
//   only when the word it fetches is guaranteed a slot in the 2-entry
//   holding buffer, captures fifo_rd_data one cycle later and presents it
//   as a valid/ready stream at one beat per cycle.
//   Optional macro FIFO_STREAM_OUT_STATS_EN adds the beat_count output.
// Ports:
//   clk, rst      : FIFO read clock, asynchronous active-high reset
//   fifo_empty    : FIFO empty flag (may be pessimistic)
//   fifo_rd_en    : FIFO read strobe
//   fifo_rd_data  : FIFO read data, valid RD_LATENCY cycles after rd_en
//   m_valid       : stream valid
//   m_ready       : stream ready from the consumer
//   m_data        : stream data (buffer head)
//   beat_count    : accepted beats, wraps (macro-enabled only)
module fifo_stream_out
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_STREAM_OUT_STATS_EN
  ,
  output logic [BEAT_CNT_W-1:0] beat_count
`endif
);

  // The in-flight tracking below assumes exactly one cycle of read latency.
  generate
    if (RD_LATENCY != 1) begin : g_bad_latency
      $error("fifo_stream_out: only RD_LATENCY=1 is supported");
    end
  endgenerate

  cnt_t       count;
  logic       inflight;
  logic       pop;
  logic [2:0] occupancy;

  assign m_valid = (count != CNT_EMPTY);
  assign pop     = m_valid && m_ready;

  // Occupancy seen by a read issued now: what is buffered, plus the word
  // already on its way, minus the beat leaving this cycle. A new read is
  // safe only if that leaves room. This makes fifo_rd_en combinational
  // on m_ready, which is what allows a full buffer to keep streaming.
  assign occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = !rst && !fifo_empty && (occupancy < {1'b0, CNT_TWO});

  // A read issued this cycle returns data next cycle; remembering that
  // here is what decides whether fifo_rd_data is captured. Clearing it on
  // reset drops any word that was in flight when reset hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  stream_skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head_data (m_data),
    .count     (count)
  );

`ifdef FIFO_STREAM_OUT_STATS_EN
  // Counts every accepted beat; natural wrap at 2^BEAT_CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count <= '0;
    end else if (pop) begin
      beat_count <= beat_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// tb_fifo_stream_out
//   Drives fifo_stream_out from a queue-based FIFO model and checks the
//   output stream with a scoreboard. Words are pushed to the expected
//   queue when loaded into the FIFO model; a monitor pops and compares on
//   every accepted beat and checks stream invariants each cycle.
module tb_fifo_stream_out;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef FIFO_STREAM_OUT_STATS_EN
  logic [31:0]   beat_count;
`endif

  always #5 clk = ~clk;

  fifo_stream_out #(
    .DATA_WIDTH (DW),
    .RD_LATENCY (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data)
`ifdef FIFO_STREAM_OUT_STATS_EN
    ,
    .beat_count   (beat_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];

  bit ready_rand   = 1'b0;
  bit ready_fixed  = 1'b1;
  int gap_pct      = 0;
  bit empty_ovr_en = 1'b0;
  bit empty_ovr_val = 1'b1;
  int phase_id     = 0;

  // monitor-owned bookkeeping
  int            cyc = 0;
  int            occ = 0;
  int            mon_phase = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [31:0]   beats_model = '0;
  int            ph_rd = 0;
  int            ph_pops = 0;
  int            ph_first_rd = -1;
  int            ph_last_rd = -1;
  int            ph_first_valid = -1;
  int            ph_first_pop = -1;
  int            ph_last_pop = -1;
  logic [DW-1:0] ph_first_data = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // consumer ready and FIFO empty flag for the coming cycle
  task automatic applyStimulus();
    m_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
    if (empty_ovr_en) begin
      fifo_empty = empty_ovr_val || (src_q.size() == 0);
    end else begin
      fifo_empty = (src_q.size() == 0) || (int'($urandom_range(0, 99)) < gap_pct);
    end
  endtask

  task automatic pushWord(input logic [DW-1:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic newPhase();
    phase_id++;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < budget) begin
      waitCycles(1);
      n++;
    end
    checkOutput("drain_scoreboard_empty", exp_q.size(), 0);
  endtask

  // FIFO model: a read strobe seen in a cycle returns the next queued word
  // just after the following edge; otherwise the data bus carries junk.
  initial begin
    bit rd_taken;
    fifo_empty   = 1'b0;
    m_ready      = 1'b1;
    fifo_rd_data = '0;
    forever begin
      @(negedge clk);
      rd_taken = fifo_rd_en;
      @(posedge clk);
      #1;
      if (rd_taken && !rst && src_q.size() > 0) begin
        fifo_rd_data = src_q.pop_front();
      end else begin
        fifo_rd_data = DW'($urandom);
      end
      applyStimulus();
    end
  end

  // Monitor: scoreboard compare on accepted beats plus per-cycle invariants.
  always @(negedge clk) begin
    cyc++;
    if (mon_phase != phase_id) begin
      mon_phase      = phase_id;
      ph_rd          = 0;
      ph_pops        = 0;
      ph_first_rd    = -1;
      ph_last_rd     = -1;
      ph_first_valid = -1;
      ph_first_pop   = -1;
      ph_last_pop    = -1;
      ph_first_data  = '0;
    end
    if (rst) begin
      occ         = 0;
      prev_stall  = 1'b0;
      beats_model = '0;
    end else begin
      if (fifo_empty) checkOutput("rd_en_while_empty", {31'b0, fifo_rd_en}, 0);
      checkOutput("occupancy_le_2", {31'b0, (occ <= 2)}, 1);
      if (prev_stall) begin
        checkOutput("hold_valid", {31'b0, m_valid}, 1);
        checkOutput("hold_data", {24'b0, m_data}, {24'b0, prev_data});
      end
      if (m_valid && ph_first_valid < 0) ph_first_valid = cyc;
      if (fifo_rd_en) begin
        ph_rd++;
        if (ph_first_rd < 0) ph_first_rd = cyc;
        ph_last_rd = cyc;
      end
      if (m_valid && m_ready) begin
        checkOutput("beat_expected", {31'b0, (exp_q.size() != 0)}, 1);
        if (exp_q.size() != 0) begin
          checkOutput("beat_data", {24'b0, m_data}, {24'b0, exp_q.pop_front()});
        end
        if (ph_first_pop < 0) begin
          ph_first_pop  = cyc;
          ph_first_data = m_data;
        end
        ph_last_pop = cyc;
        ph_pops++;
        beats_model = beats_model + 1;
        occ--;
      end
      if (fifo_rd_en) occ++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    #600000;
    bad++;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [DW-1:0] basic_words [3];
    int            loaded;
    logic [31:0]   beat_snap;
    basic_words = '{8'h11, 8'h22, 8'h33};

    // reset state, with fifo_empty low so the read gating is exercised
    rst = 1'b1;
    #3;
    checkOutput("reset_m_valid", {31'b0, m_valid}, 0);
    checkOutput("reset_m_data", {24'b0, m_data}, 0);
    checkOutput("reset_rd_en", {31'b0, fifo_rd_en}, 0);
    waitCycles(2);
    rst = 1'b0;
`ifdef FIFO_STREAM_OUT_STATS_EN
    checkOutput("reset_beat_count", beat_count, 0);
`endif

    // basic read, consumer always ready
    $display("[TB] basic read");
    newPhase();
    ready_fixed = 1'b1;
    foreach (basic_words[i]) pushWord(basic_words[i]);
    waitCycles(10);
    checkOutput("basic_reads", ph_rd, 3);
    checkOutput("basic_reads_consecutive", ph_last_rd - ph_first_rd, 2);
    checkOutput("basic_latency", ph_first_valid - ph_first_rd, 2);
    checkOutput("basic_beats", ph_pops, 3);
    checkOutput("basic_beats_consecutive", ph_last_pop - ph_first_pop, 2);
    checkOutput("basic_first_data", {24'b0, ph_first_data}, 32'h11);
    checkOutput("basic_valid_after", {31'b0, m_valid}, 0);

    // back-pressure: only two reads may be outstanding
    $display("[TB] back-pressure");
    newPhase();
    ready_fixed = 1'b0;
    for (int i = 1; i <= 8; i++) pushWord(DW'(i));
    waitCycles(10);
    checkOutput("bp_reads", ph_rd, 2);
    checkOutput("bp_occupancy", occ, 2);
    checkOutput("bp_valid", {31'b0, m_valid}, 1);
    checkOutput("bp_head", {24'b0, m_data}, 32'h01);
    newPhase();
    ready_fixed = 1'b1;
    waitCycles(14);
    checkOutput("bp_beats", ph_pops, 8);
    checkOutput("bp_beats_consecutive", ph_last_pop - ph_first_pop, 7);
    checkOutput("bp_first_data", {24'b0, ph_first_data}, 32'h01);
    checkOutput("bp_drained", exp_q.size(), 0);

    // single-cycle empty deassertion
    $display("[TB] empty pulse");
    newPhase();
    empty_ovr_en  = 1'b1;
    empty_ovr_val = 1'b1;
    pushWord(8'h3C);
    pushWord(8'hC3);
    waitCycles(3);
    empty_ovr_val = 1'b0;
    waitCycles(1);
    empty_ovr_val = 1'b1;
    waitCycles(6);
    checkOutput("pulse_reads", ph_rd, 1);
    checkOutput("pulse_beats", ph_pops, 1);
    checkOutput("pulse_data", {24'b0, ph_first_data}, 32'h3C);
    checkOutput("pulse_left", exp_q.size(), 1);
    empty_ovr_en = 1'b0;
    waitDrain(20);

    // random ready and empty gaps
    $display("[TB] random traffic");
    newPhase();
    ready_rand = 1'b1;
    gap_pct    = 30;
    loaded     = 0;
    while (loaded < 1000) begin
      if (src_q.size() < 6 && $urandom_range(0, 1) == 1) begin
        pushWord(DW'($urandom));
        loaded++;
      end
      waitCycles(1);
    end
    waitDrain(400);
    checkOutput("random_beats", ph_pops, 1000);
`ifdef FIFO_STREAM_OUT_STATS_EN
    checkOutput("random_beat_count", beat_count, beats_model);
`endif
    ready_rand  = 1'b0;
    ready_fixed = 1'b1;
    gap_pct     = 0;

    // reset while streaming with a read in flight
    $display("[TB] reset mid-stream");
    for (int i = 0; i < 20; i++) pushWord(DW'(8'h40 + i));
    waitCycles(6);
    checkOutput("mid_streaming", {31'b0, m_valid}, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_valid", {31'b0, m_valid}, 0);
    checkOutput("mid_reset_data", {24'b0, m_data}, 0);
    checkOutput("mid_reset_rd_en", {31'b0, fifo_rd_en}, 0);
    src_q.delete();
    exp_q.delete();
    pushWord(8'hA5);
    pushWord(8'h5A);
    waitCycles(2);
    newPhase();
    rst = 1'b0;
    waitCycles(8);
    checkOutput("mid_first_beat", {24'b0, ph_first_data}, 32'hA5);
    checkOutput("mid_beats", ph_pops, 2);
    checkOutput("mid_drained", exp_q.size(), 0);

`ifdef FIFO_STREAM_OUT_STATS_EN
    // beat counter: 300 beats from reset, then wrap from all-ones
    $display("[TB] stats");
    rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    newPhase();
    for (int i = 0; i < 300; i++) pushWord(DW'($urandom));
    waitDrain(400);
    checkOutput("stats_beats", ph_pops, 300);
    checkOutput("stats_300", beat_count, 300);
    beat_snap = beats_model;
    force dut.beat_count = 32'hFFFF_FFFF;
    #1;
    release dut.beat_count;
    pushWord(8'h77);
    waitDrain(20);
    checkOutput("stats_wrap", beat_count, 32'hFFFF_FFFF + (beats_model - beat_snap));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
